// File: rtl/vga_timing_ctrl_p_if.sv
// Purpose: pixel-side bundle of the VGA timing controller (FIFO data in, DAC/timing out).
// Latency: none, wires only.
// Backpressure: none; oRequest is a fetch strobe that the FIFO must honour.
// Ports: iZOOM_MODE, iRed/iGreen/iBlue flow into the controller. oRequest, oVGA_*,
//        oH_Cont/oV_Cont and the row/frame markers flow out of it.
interface vga_timing_ctrl_p_if #(
    parameter int COLOR_W = 8,
    parameter int CNT_W   = 12
);
    logic               iZOOM_MODE;
    logic [COLOR_W-1:0] iRed;
    logic [COLOR_W-1:0] iGreen;
    logic [COLOR_W-1:0] iBlue;
    logic               oRequest;
    logic [COLOR_W-1:0] oVGA_R;
    logic [COLOR_W-1:0] oVGA_G;
    logic [COLOR_W-1:0] oVGA_B;
    logic               oVGA_H_SYNC;
    logic               oVGA_V_SYNC;
    logic               oVGA_BLANK_N;
    logic [CNT_W-1:0]   oH_Cont;
    logic [CNT_W-1:0]   oV_Cont;
    logic               oFrameStart;
    logic               oRowStart;
    logic               oRowRepeat;

    // Controller side.
    modport master (
        input  iZOOM_MODE, iRed, iGreen, iBlue,
        output oRequest, oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC,
               oVGA_BLANK_N, oH_Cont, oV_Cont, oFrameStart, oRowStart, oRowRepeat
    );

    // FIFO / DAC side.
    modport slave (
        output iZOOM_MODE, iRed, iGreen, iBlue,
        input  oRequest, oVGA_R, oVGA_G, oVGA_B, oVGA_H_SYNC, oVGA_V_SYNC,
               oVGA_BLANK_N, oH_Cont, oV_Cont, oFrameStart, oRowStart, oRowRepeat
    );
endinterface

// File: rtl/vga_timing_ctrl_p.sv
// Purpose: parametrised VGA timing generator with look-ahead pixel requests and 2x zoom.
// Latency: oRequest leads pixel consumption by REQ_LEAD cycles; DAC/sync/marker outputs
//          are registered, one cycle behind the counter; oH_Cont/oV_Cont/oRequest are not.
// Backpressure: none; the FIFO must deliver data exactly REQ_LEAD cycles after oRequest.
// Ports: iCLK pixel clock, iRST_N async active-low reset, bus = pixel/DAC bundle (master).
module vga_timing_ctrl_p #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0,
    parameter int COLOR_W  = 8,
    parameter int REQ_LEAD = 1,
    parameter int CNT_W    = 12
) (
    input logic                  iCLK,
    input logic                  iRST_N,
    vga_timing_ctrl_p_if.master  bus
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [CNT_W-1:0] P_INIT   = CNT_W'(REQ_LEAD);
    localparam logic             HS_ON    = (HS_POL != 0);
    localparam logic             VS_ON    = (VS_POL != 0);

    // Display counter (h, v) and a look-ahead twin (ph, pv) running REQ_LEAD
    // cycles ahead. Because REQ_LEAD < H_TOTAL the twin can start at (REQ_LEAD, 0)
    // and simply count alongside, which gives the wrapped future position for free.
    logic [CNT_W-1:0] h, v, ph, pv;
    logic             zoom_q;
    logic             c_first;   // display counter is still in the post-reset frame
    logic             p_first;   // look-ahead counter is still in the post-reset frame
    logic             p_ahead;   // look-ahead has entered a frame the display has not

    logic [COLOR_W-1:0] red_q, green_q, blue_q;
    logic               hs_q, vs_q, blank_n_q;
    logic               frame_start_q, row_start_q, row_repeat_q;

    logic p_active, c_active, req_zoom, request;

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            h       <= '0;
            v       <= '0;
            ph      <= P_INIT;
            pv      <= '0;
            zoom_q  <= 1'b0;
            c_first <= 1'b1;
            p_first <= 1'b1;
            p_ahead <= 1'b0;
        end else begin
            if (h == H_LAST) begin
                h <= '0;
                v <= (v == V_LAST) ? '0 : v + 1'b1;
            end else begin
                h <= h + 1'b1;
            end

            if (ph == H_LAST) begin
                ph <= '0;
                pv <= (pv == V_LAST) ? '0 : pv + 1'b1;
            end else begin
                ph <= ph + 1'b1;
            end

            // With REQ_LEAD >= 1 these two frame-end events never share a cycle.
            if (ph == H_LAST && pv == V_LAST) begin
                p_first <= 1'b0;
                p_ahead <= 1'b1;
            end
            if (h == H_LAST && v == V_LAST) begin
                zoom_q  <= bus.iZOOM_MODE;
                c_first <= 1'b0;
                p_ahead <= 1'b0;
            end
        end
    end

    // Requests issued for the first REQ_LEAD pixels of a new frame go out before
    // the zoom latch updates; they use the value about to be latched so the
    // per-frame request count matches the mode the frame is displayed in.
    always_comb begin
        p_active = (ph < H_ACT) && (pv < V_ACT);
        c_active = !c_first && (h < H_ACT) && (v < V_ACT);
        req_zoom = p_ahead ? bus.iZOOM_MODE : zoom_q;
        request  = !p_first && p_active && !(req_zoom && ph[0]);
    end

    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            red_q         <= '0;
            green_q       <= '0;
            blue_q        <= '0;
            hs_q          <= ~HS_ON;
            vs_q          <= ~VS_ON;
            blank_n_q     <= 1'b0;
            frame_start_q <= 1'b0;
            row_start_q   <= 1'b0;
            row_repeat_q  <= 1'b0;
        end else begin
            hs_q      <= (h >= HS_START && h < HS_END) ? HS_ON : ~HS_ON;
            vs_q      <= (v >= VS_START && v < VS_END) ? VS_ON : ~VS_ON;
            blank_n_q <= c_active;

            // Odd columns in zoom keep the previous pixel: the FIFO was not asked
            // for them, so whatever sits on iRed/iGreen/iBlue is ignored.
            if (!c_active) begin
                red_q   <= '0;
                green_q <= '0;
                blue_q  <= '0;
            end else if (!(zoom_q && h[0])) begin
                red_q   <= bus.iRed;
                green_q <= bus.iGreen;
                blue_q  <= bus.iBlue;
            end

            frame_start_q <= (h == '0) && (v == '0);
            row_start_q   <= (h == '0) && (v < V_ACT);
            row_repeat_q  <= (h == '0) && (v < V_ACT) && zoom_q && v[0];
        end
    end

    assign bus.oRequest     = request;
    assign bus.oVGA_R       = red_q;
    assign bus.oVGA_G       = green_q;
    assign bus.oVGA_B       = blue_q;
    assign bus.oVGA_H_SYNC  = hs_q;
    assign bus.oVGA_V_SYNC  = vs_q;
    assign bus.oVGA_BLANK_N = blank_n_q;
    assign bus.oH_Cont      = h;
    assign bus.oV_Cont      = v;
    assign bus.oFrameStart  = frame_start_q;
    assign bus.oRowStart    = row_start_q;
    assign bus.oRowRepeat   = row_repeat_q;
endmodule

// File: tb/tb_vga_timing_ctrl_p.sv
// Bench for vga_timing_ctrl_p on a reduced 16x10 mode with REQ_LEAD=3,
// high-active H sync and low-active V sync.
module tb_vga_timing_ctrl_p;
    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;   // 16
    localparam int VT = VA + VF + VS + VB;   // 10
    localparam int FT = HT * VT;             // 160
    localparam int L  = 3;
    localparam bit HSP = 1'b1;
    localparam bit VSP = 1'b0;

    logic clk;
    logic rst_n;

    vga_timing_ctrl_p_if #(.COLOR_W(8), .CNT_W(8)) vif ();

    vga_timing_ctrl_p #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1), .VS_POL(0), .COLOR_W(8), .REQ_LEAD(L), .CNT_W(8)
    ) dut (
        .iCLK  (clk),
        .iRST_N(rst_n),
        .bus   (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cur_n  = -1;
    int seg    = 0;

    // zoom input schedule for the current segment
    bit z_before, z_after;
    int z_chg;

    logic [7:0] din [0:2047];
    logic [7:0] dval;
    logic [7:0] er;
    int req_cnt [0:7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s seg=%0d n=%0d: got %0h expected %0h", name, seg, cur_n, act, exp);
        end
    endtask

    function automatic int hof(input int m); return (m % FT) % HT; endfunction
    function automatic int vof(input int m); return (m % FT) / HT; endfunction
    function automatic int fof(input int m); return m / FT; endfunction

    function automatic bit zin(input int m);
        return (m >= z_chg) ? z_after : z_before;
    endfunction

    // zoom mode a frame is displayed in: the input value on the frame's last cycle
    // before it; the post-reset frame is always unzoomed
    function automatic bit zf(input int f);
        return (f == 0) ? 1'b0 : zin(f * FT - 1);
    endfunction

    function automatic bit model_req(input int m);
        int q, f, hh, vv;
        q  = m + L;
        f  = fof(q);
        hh = hof(q);
        vv = vof(q);
        return (f >= 1) && (hh < HA) && (vv < VA) && !(zf(f) && (hh % 2 == 1));
    endfunction

    task automatic check_reset();
        chk("rst_request", 32'(vif.oRequest), 32'd0);
        chk("rst_blank_n", 32'(vif.oVGA_BLANK_N), 32'd0);
        chk("rst_red", 32'(vif.oVGA_R), 32'd0);
        chk("rst_green", 32'(vif.oVGA_G), 32'd0);
        chk("rst_blue", 32'(vif.oVGA_B), 32'd0);
        chk("rst_hsync", 32'(vif.oVGA_H_SYNC), 32'(!HSP));
        chk("rst_vsync", 32'(vif.oVGA_V_SYNC), 32'(!VSP));
        chk("rst_frame_start", 32'(vif.oFrameStart), 32'd0);
        chk("rst_row_start", 32'(vif.oRowStart), 32'd0);
        chk("rst_row_repeat", 32'(vif.oRowRepeat), 32'd0);
        chk("rst_h_cont", 32'(vif.oH_Cont), 32'd0);
        chk("rst_v_cont", 32'(vif.oV_Cont), 32'd0);
    endtask

    // Per-cycle comparison against the frame-arithmetic model; n counts clock
    // edges since reset release.
    task automatic check_outputs(input int n);
        int s, sh, sv, sf;
        bit act, e_req, e_hs, e_vs, e_fs, e_rs, e_rr;
        e_req = model_req(n);
        chk("request", 32'(vif.oRequest), 32'(e_req));
        chk("h_cont", 32'(vif.oH_Cont), 32'(hof(n)));
        chk("v_cont", 32'(vif.oV_Cont), 32'(vof(n)));
        if (n == 0) begin
            act = 1'b0; er = 8'h00;
            e_hs = !HSP; e_vs = !VSP; e_fs = 1'b0; e_rs = 1'b0; e_rr = 1'b0;
        end else begin
            s  = n - 1;
            sh = hof(s); sv = vof(s); sf = fof(s);
            act = (sf >= 1) && (sh < HA) && (sv < VA);
            if (!act) er = 8'h00;
            else if (!(zf(sf) && (sh % 2 == 1))) er = din[s];
            e_hs = (sh >= HA + HF && sh < HA + HF + HS) ? HSP : !HSP;
            e_vs = (sv >= VA + VF && sv < VA + VF + VS) ? VSP : !VSP;
            e_fs = (sh == 0) && (sv == 0);
            e_rs = (sh == 0) && (sv < VA);
            e_rr = e_rs && zf(sf) && (sv % 2 == 1);
        end
        chk("blank_n", 32'(vif.oVGA_BLANK_N), 32'(act));
        chk("red", 32'(vif.oVGA_R), 32'(er));
        chk("green", 32'(vif.oVGA_G), 32'(act ? (er ^ 8'hFF) : 8'h00));
        chk("blue", 32'(vif.oVGA_B), 32'(act ? (er ^ 8'h5A) : 8'h00));
        chk("hsync", 32'(vif.oVGA_H_SYNC), 32'(e_hs));
        chk("vsync", 32'(vif.oVGA_V_SYNC), 32'(e_vs));
        chk("frame_start", 32'(vif.oFrameStart), 32'(e_fs));
        chk("row_start", 32'(vif.oRowStart), 32'(e_rs));
        chk("row_repeat", 32'(vif.oRowRepeat), 32'(e_rr));
        if (vif.oRequest === 1'b1) req_cnt[fof(n + L)]++;
        // FIFO model: requested data appears REQ_LEAD cycles later
        if (e_req) begin
            din[n + L] = dval;
            dval = dval + 8'd1;
        end
    endtask

    // hand-computed expectations pinning the model itself
    task automatic check_literals(input int n);
        if (seg == 0) begin
            if (n == 156) chk("lit_no_req_h12", 32'(vif.oRequest), 32'd0);
            if (n == 157) chk("lit_first_req_h13", 32'(vif.oRequest), 32'd1);
            if (n == 10)  chk("lit_hs_before", 32'(vif.oVGA_H_SYNC), 32'd0);
            if (n == 11)  chk("lit_hs_start", 32'(vif.oVGA_H_SYNC), 32'd1);
            if (n == 14)  chk("lit_hs_end", 32'(vif.oVGA_H_SYNC), 32'd0);
            if (n == 112) chk("lit_vs_before", 32'(vif.oVGA_V_SYNC), 32'd1);
            if (n == 113) chk("lit_vs_start", 32'(vif.oVGA_V_SYNC), 32'd0);
            if (n == 161) chk("lit_pix0", 32'(vif.oVGA_R), 32'd0);
            if (n == 162) chk("lit_pix1", 32'(vif.oVGA_R), 32'd1);
            if (n == 163) chk("lit_pix2", 32'(vif.oVGA_R), 32'd2);
            if (n == 162) chk("lit_pix1_green", 32'(vif.oVGA_G), 32'hFE);
        end else begin
            if (n == 1)   chk("lit_frame0_blank", 32'(vif.oVGA_BLANK_N), 32'd0);
            if (n == 1)   chk("lit_frame_start0", 32'(vif.oFrameStart), 32'd1);
            if (n == 161) chk("lit_frame1_blank", 32'(vif.oVGA_BLANK_N), 32'd1);
            if (n == 161) chk("lit_zoom_pix0", 32'(vif.oVGA_R), 32'd0);
            if (n == 162) chk("lit_zoom_pix1", 32'(vif.oVGA_R), 32'd0);
            if (n == 163) chk("lit_zoom_pix2", 32'(vif.oVGA_R), 32'd1);
            if (n == 161) chk("lit_row_start", 32'(vif.oRowStart), 32'd1);
            if (n == 161) chk("lit_row_rep_even", 32'(vif.oRowRepeat), 32'd0);
            if (n == 177) chk("lit_row_rep_odd", 32'(vif.oRowRepeat), 32'd1);
        end
    endtask

    task automatic drive(input int n);
        vif.iZOOM_MODE = zin(n);
        vif.iRed       = din[n];
        vif.iGreen     = din[n] ^ 8'hFF;
        vif.iBlue      = din[n] ^ 8'h5A;
    endtask

    // Releases reset on the current falling edge and runs ncyc cycles.
    task automatic run_seg(input int ncyc);
        for (int i = 0; i < 2048; i++) din[i] = 8'hEE;
        for (int i = 0; i < 8; i++) req_cnt[i] = 0;
        dval = 8'h00;
        er   = 8'h00;
        vif.iZOOM_MODE = zin(0);
        rst_n = 1'b1;
        for (int n = 0; n < ncyc; n++) begin
            if (n > 0) @(negedge clk);
            cur_n = n;
            check_outputs(n);
            check_literals(n);
            drive(n);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        vif.iZOOM_MODE = 1'b0;
        vif.iRed = 8'h00; vif.iGreen = 8'h00; vif.iBlue = 8'h00;

        // segment 0: zoom off throughout
        seg = 0; z_before = 1'b0; z_after = 1'b0; z_chg = 1 << 30;
        repeat (3) @(negedge clk);
        check_reset();
        run_seg(515);   // stops at frame 3, h=2, v=2 with a request pending
        chk("cnt_frame0", 32'(req_cnt[0]), 32'd0);
        chk("cnt_frame1", 32'(req_cnt[1]), 32'd48);
        chk("cnt_frame2", 32'(req_cnt[2]), 32'd48);

        // asynchronous mid-frame reset, checked before any clock edge
        #2 rst_n = 1'b0;
        #1 cur_n = -1;
        check_reset();

        // segment 1: zoom on from reset, switched off at v=3 of frame 2
        seg = 1; z_before = 1'b1; z_after = 1'b0; z_chg = 2 * FT + 3 * HT;
        vif.iZOOM_MODE = 1'b1;
        repeat (5) @(negedge clk);
        run_seg(640);
        chk("zcnt_frame0", 32'(req_cnt[0]), 32'd0);
        chk("zcnt_frame1", 32'(req_cnt[1]), 32'd24);
        chk("zcnt_frame2", 32'(req_cnt[2]), 32'd24);
        chk("zcnt_frame3", 32'(req_cnt[3]), 32'd48);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
